nibble_serial_addsub_ctrl: RTL and testbench

Sequencing controller that performs WIDTH-bit add/subtract by running a single 4-bit add/sub slice once per clock, least-significant nibble first. The carry is chained between nibbles in a register.
Serves wide arithmetic in area-constrained datapaths where one 4-bit adder-subtractor is time-shared instead of replicated.
Start/done handshake toward the requester; the 4-bit slice is internal to the block.

---
 rtl/nibble_serial_addsub_ctrl.sv | 117 +++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_addsub_ctrl
// Brief    : WIDTH-bit add/subtract on one time-shared 4-bit slice, LS nibble
//            first, with a start/done handshake. Optional ADDSUB_SAT_EN macro
//            enables signed saturation of the final result.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_addsub_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [4:0]       w_sum;
    logic             w_last;
    logic             w_ovf;

    // One slice of the shared adder; B is inverted for subtraction.
    always_comb begin
        w_a_nib = r_a[4*r_idx +: 4];
        w_b_nib = r_b[4*r_idx +: 4] ^ {4{r_sub}};
        w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
        w_last  = (r_idx == C_LAST_IDX);
        w_ovf   = (w_a_nib[3] == w_b_nib[3]) && (w_sum[3] != w_a_nib[3]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sub   <= sub;
                        r_idx   <= '0;
                        r_carry <= sub;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    result[4*r_idx +: 4] <= w_sum[3:0];
                    r_carry              <= w_sum[4];
                    r_idx                <= r_idx + 1'b1;
                    if (w_last) begin
                        cout     <= w_sum[4];
                        overflow <= w_ovf;
`ifdef ADDSUB_SAT_EN
                        // Both operand signs agree on overflow, so A's sign picks the rail.
                        if (w_ovf) begin
                            result <= w_a_nib[3] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}};
                        end
`endif
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_addsub_ctrl
// Brief    : Table-driven, scoreboarded bench for nibble_serial_addsub_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_addsub_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    nibble_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   checks    = 0;
    int   failures  = 0;
    int   done_cnt  = 0;
    logic prev_done = 1'b0;

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] C_POS_OVF = 16'h7FFF;
    localparam logic [WIDTH-1:0] C_NEG_OVF = 16'h8000;
    localparam logic [WIDTH-1:0] C_NEG_OVF2 = 16'h8000;
`else
    localparam logic [WIDTH-1:0] C_POS_OVF = 16'h8000;
    localparam logic [WIDTH-1:0] C_NEG_OVF = 16'h7FFF;
    localparam logic [WIDTH-1:0] C_NEG_OVF2 = 16'h0000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pops one expected record.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1, expected no pending op (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("cout", 32'(cout), 32'(e.co));
                check("overflow", 32'(overflow), 32'(e.ov));
            end
            if (prev_done) begin
                checks++;
                failures++;
                $display("FAIL done_width: got done high 2 cycles, expected 1 (t=%0t)", $time);
            end
        end
        prev_done = done;
    end

    // Call just after a negedge. Drives one op, scrambles operands after accept,
    // then checks latency, busy length and the return to idle.
    task automatic do_op(input vec_t v);
        exp_t e;
        int   n;
        int   busy_cycles;
        int   lat;
        bit   got;
        a = v.a; b = v.b; sub = v.sub; start = 1'b1;
        e.res = v.res; e.co = v.co; e.ov = v.ov;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
        n = 0; busy_cycles = 0; lat = -1; got = 0;
        while (!got && n < 20) begin
            if (busy) busy_cycles++;
            if (done) begin
                got = 1;
                lat = n;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        check("done_latency", 32'(lat), 32'd4);
        check("busy_cycles", 32'(busy_cycles), 32'd5);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int   d0;
        int   dones_seen;
        int   first_done;
        int   second_done;
        exp_t e;

        vecs[0] = '{16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, C_POS_OVF, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, C_NEG_OVF, 1'b1, 1'b1};
        vecs[5] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, C_NEG_OVF2, 1'b1, 1'b1};
        vecs[7] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[8] = '{16'h7000, 16'h9000, 1'b1, C_POS_OVF == 16'h7FFF ? 16'h7FFF : 16'hE000, 1'b0, 1'b1};
        vecs[9] = '{16'h00A5, 16'h005A, 1'b0, 16'h00FF, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i]);
            check("result_hold", 32'(result), 32'(vecs[i].res));
        end

        // Second start on the 2nd RUN cycle must be ignored.
        d0 = done_cnt;
        a = 16'h0005; b = 16'h0003; sub = 1'b1; start = 1'b1;
        e.res = 16'h0002; e.co = 1'b1; e.ov = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(20);
        repeat (6) @(negedge clk);
        check("ignored_start_dones", 32'(done_cnt - d0), 32'd1);
        check("ignored_start_result", 32'(result), 32'h0002);

        // Reset on the 3rd RUN cycle discards the op.
        d0 = done_cnt;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_result", 32'(result), 32'd0);
        check("midrun_rst_done", 32'(done), 32'd0);
        repeat (8) @(negedge clk);
        check("midrun_rst_no_done", 32'(done_cnt - d0), 32'd0);
        do_op('{16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0});

        // Start held high: back-to-back accepts every N+2 cycles.
        d0 = done_cnt;
        first_done = -1; second_done = -1; dones_seen = 0;
        a = 16'h00FF; b = 16'h0001; sub = 1'b0; start = 1'b1;
        e.res = 16'h0100; e.co = 1'b0; e.ov = 1'b0;
        sb_q.push_back(e);
        sb_q.push_back(e);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 11) start = 1'b0;
            if (done) begin
                dones_seen++;
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
        end
        check("held_start_dones", 32'(dones_seen), 32'd2);
        check("held_start_first", 32'(first_done), 32'd4);
        check("held_start_spacing", 32'(second_done - first_done), 32'd6);
        wait_idle(20);
        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
